// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array row FIFO feed path:
// word width, default row count, row-counter width and the writer state encoding.
package sa_pkg;
  localparam int DATA_W      = 9;
  localparam int ROW_DEFAULT = 3;
  localparam int ROW_CNT_W   = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    FLUSH   = 1'b1
  } state_t;
endpackage

// File: rtl/row_fifo_scatter_if.sv
// Serial word stream into the row scatter writer.
// Handshake: a word transfers on a rising edge where i_valid && o_ready are both high;
// the master may change i_data/i_valid freely when o_ready is low, and o_ready depends
// only on writer state, never on i_valid.
interface row_fifo_scatter_if
  import sa_pkg::*;
  ;
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;

  modport master (output i_data, output i_valid, input o_ready);
  modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/row_fifo_scatter.sv
// Collects ROW serial words into one row vector (word 0 in the MSB slice) and then
// strobes every row FIFO in the same cycle once none of them is full.
module row_fifo_scatter
  import sa_pkg::*;
#(
  parameter int ROW = ROW_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  row_fifo_scatter_if.slave     s_in,
  input  logic                  i_clear,
  input  logic [ROW-1:0]        i_fifo_full,
  output logic [DATA_W*ROW-1:0] o_data,
  output logic [ROW-1:0]        o_write_enable,
  output logic [ROW_CNT_W-1:0]  o_row_count,
  output state_t                o_state
);

  localparam int IDX_W = (ROW > 1) ? $clog2(ROW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROW - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ready;
  logic             accept;
  logic             write_d;

  assign ready        = (state_q == COLLECT);
  assign s_in.o_ready = ready;
  assign o_state      = state_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    write_d = 1'b0;
    // Clear wins over both a same-edge accept and a pending flush write.
    accept  = ready && s_in.i_valid && !i_clear;
    if (i_clear) begin
      state_d = COLLECT;
      idx_d   = '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = FLUSH;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (i_fifo_full == '0) begin
            write_d = 1'b1;
            state_d = COLLECT;
          end
        end
        default: begin
          state_d = COLLECT;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= COLLECT;
      idx_q          <= '0;
      o_write_enable <= '0;
      o_row_count    <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      o_write_enable <= write_d ? '1 : '0;
      if (write_d) begin
        o_row_count <= o_row_count + 1'b1;
      end
    end
  end

  // Slice k of the vector is word k of the row, counted from the MSB end.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data <= '0;
    end else if (accept) begin
      for (int k = 0; k < ROW; k++) begin
        if (idx_q == IDX_W'(k)) begin
          o_data[(ROW-k)*DATA_W-1 -: DATA_W] <= s_in.i_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_row_fifo_scatter.sv
// Directed bench for row_fifo_scatter (ROW=3): scoreboard of {row count, row vector}
// pushed as words are accepted and popped on each write strobe.
module tb_row_fifo_scatter;
  import sa_pkg::*;

  localparam int R    = 3;
  localparam int VW   = DATA_W * R;
  localparam int SB_W = ROW_CNT_W + VW;

  logic                 i_clk;
  logic                 i_rst_n;
  logic                 i_clear;
  logic [R-1:0]         i_fifo_full;
  logic [VW-1:0]        o_data;
  logic [R-1:0]         o_write_enable;
  logic [ROW_CNT_W-1:0] o_row_count;
  state_t               o_state;

  row_fifo_scatter_if bus ();

  row_fifo_scatter #(.ROW(R)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .s_in           (bus.slave),
    .i_clear        (i_clear),
    .i_fifo_full    (i_fifo_full),
    .o_data         (o_data),
    .o_write_enable (o_write_enable),
    .o_row_count    (o_row_count),
    .o_state        (o_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // scoreboard state
  logic [SB_W-1:0]      exp_q[$];
  int                   strobe_q[$];
  logic [VW-1:0]        cur_vec = '0;
  int                   cur_idx = 0;
  logic [ROW_CNT_W-1:0] exp_cnt = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_accept(input logic [DATA_W-1:0] d);
    cur_vec[(R-cur_idx)*DATA_W-1 -: DATA_W] = d;
    if (cur_idx == R - 1) begin
      exp_cnt = exp_cnt + 1'b1;
      exp_q.push_back({exp_cnt, cur_vec});
      cur_idx = 0;
    end else begin
      cur_idx++;
    end
  endtask

  // Leaves i_valid high so consecutive calls form a continuous stream.
  task automatic send_word(input logic [DATA_W-1:0] d);
    int n;
    n = 0;
    bus.i_data  = d;
    bus.i_valid = 1'b1;
    while (!bus.o_ready && n < 50) begin
      step();
      n++;
    end
    check("send_ready_timeout", 64'(n < 50), 64'd1);
    if (n < 50) begin
      step();
      model_accept(d);
    end
  endtask

  task automatic idle(input int n);
    bus.i_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // strobe monitor: sampled mid-cycle
  always @(negedge i_clk) begin
    if (i_rst_n && o_write_enable != '0) begin
      logic [SB_W-1:0] e;
      check("we_all_ones", 64'(o_write_enable), 64'(3'b111));
      strobe_q.push_back(cyc);
      check("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("row_vector", 64'(o_data), 64'(e[VW-1:0]));
        check("row_count", 64'(o_row_count), 64'(e[SB_W-1:VW]));
      end
    end
  end

  initial begin
    i_rst_n     = 1'b0;
    i_clear     = 1'b0;
    i_fifo_full = '0;
    bus.i_data  = '0;
    bus.i_valid = 1'b0;
    #22;
    i_rst_n = 1'b1;
    step();

    // reset state
    check("rst_ready", 64'(bus.o_ready), 64'd1);
    check("rst_we", 64'(o_write_enable), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_count", 64'(o_row_count), 64'd0);
    check("rst_state", 64'(o_state), 64'(COLLECT));

    // basic row, ready low exactly one cycle
    send_word(9'h101);
    send_word(9'h102);
    send_word(9'h103);
    bus.i_valid = 1'b0;
    check("basic_ready_low", 64'(bus.o_ready), 64'd0);
    check("basic_state_flush", 64'(o_state), 64'(FLUSH));
    step();
    check("basic_ready_back", 64'(bus.o_ready), 64'd1);
    check("basic_we", 64'(o_write_enable), 64'(3'b111));
    check("basic_vec", 64'(o_data), 64'({9'h101, 9'h102, 9'h103}));
    check("basic_cnt", 64'(o_row_count), 64'd1);
    idle(2);
    check("basic_we_drop", 64'(o_write_enable), 64'd0);

    // FIFO full holds the row in FLUSH
    i_fifo_full = 3'b010;
    send_word(9'h011);
    send_word(9'h022);
    send_word(9'h033);
    bus.i_valid = 1'b1;
    bus.i_data  = 9'h1EE;
    for (int i = 0; i < 5; i++) begin
      check("full_we", 64'(o_write_enable), 64'd0);
      check("full_ready", 64'(bus.o_ready), 64'd0);
      check("full_data", 64'(o_data), 64'({9'h011, 9'h022, 9'h033}));
      step();
    end
    bus.i_valid = 1'b0;
    i_fifo_full = '0;
    step();
    check("full_release_we", 64'(o_write_enable), 64'(3'b111));
    idle(2);

    // clear mid-row with a word presented
    send_word(9'h055);
    send_word(9'h066);
    bus.i_data  = 9'h1FF;
    bus.i_valid = 1'b1;
    i_clear     = 1'b1;
    step();
    i_clear     = 1'b0;
    bus.i_valid = 1'b0;
    cur_idx     = 0;
    check("clr_state", 64'(o_state), 64'(COLLECT));
    check("clr_cnt", 64'(o_row_count), 64'(exp_cnt));
    idle(3);
    send_word(9'h0AA);
    send_word(9'h0BB);
    send_word(9'h0CC);
    bus.i_valid = 1'b0;
    step();
    check("clr_next_vec", 64'(o_data), 64'({9'h0AA, 9'h0BB, 9'h0CC}));
    idle(2);

    // clear during FLUSH discards the pending row
    i_fifo_full = 3'b100;
    send_word(9'h0D1);
    send_word(9'h0D2);
    send_word(9'h0D3);
    bus.i_valid = 1'b0;
    step();
    i_clear = 1'b1;
    step();
    i_clear = 1'b0;
    void'(exp_q.pop_back());
    exp_cnt     = exp_cnt - 1'b1;
    i_fifo_full = '0;
    check("clrf_state", 64'(o_state), 64'(COLLECT));
    check("clrf_we", 64'(o_write_enable), 64'd0);
    step();
    check("clrf_we_after", 64'(o_write_enable), 64'd0);
    check("clrf_cnt", 64'(o_row_count), 64'(exp_cnt));

    // back-to-back rows with continuous valid
    strobe_q.delete();
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < R; w++) send_word(9'($urandom_range(0, 511)));
    end
    idle(3);
    check("b2b_strobes", 64'(strobe_q.size()), 64'd4);
    for (int i = 1; i < strobe_q.size(); i++) begin
      check("b2b_period", 64'(strobe_q[i] - strobe_q[i-1]), 64'd4);
    end

    // async reset while in FLUSH
    i_fifo_full = 3'b001;
    send_word(9'h1A1);
    send_word(9'h1A2);
    send_word(9'h1A3);
    bus.i_valid = 1'b0;
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_we", 64'(o_write_enable), 64'd0);
    check("arst_ready", 64'(bus.o_ready), 64'd1);
    check("arst_data", 64'(o_data), 64'd0);
    check("arst_count", 64'(o_row_count), 64'd0);
    exp_q.delete();
    exp_cnt     = '0;
    cur_idx     = 0;
    i_fifo_full = '0;
    #2;
    i_rst_n = 1'b1;
    step();
    send_word(9'h013);
    send_word(9'h024);
    send_word(9'h035);
    bus.i_valid = 1'b0;
    step();
    check("arst_next_vec", 64'(o_data), 64'({9'h013, 9'h024, 9'h035}));
    idle(2);

    // row counter wrap
    #2;
    force dut.o_row_count = 16'hFFFF;
    #1;
    release dut.o_row_count;
    exp_cnt = 16'hFFFF;
    check("wrap_preload", 64'(o_row_count), 64'hFFFF);
    step();
    send_word(9'h0F0);
    send_word(9'h0F1);
    send_word(9'h0F2);
    bus.i_valid = 1'b0;
    step();
    check("wrap_count", 64'(o_row_count), 64'h0000);
    idle(3);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
